// File: rtl/aoc_pkg.sv
// Shared types and sizing for the bank scan sequencer.
// Widths come from `TX_DATA_WIDTH, `BANK_ADDR_WIDTH and `COL_ADDR_WIDTH.
// Each one defaults to 8 when the build does not define it.
// The optional stall counter is enabled by defining SCAN_STATS_EN.
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 8
`endif

package aoc_pkg;
   localparam int DATA_W = `TX_DATA_WIDTH;
   localparam int ROW_W  = `BANK_ADDR_WIDTH;
   localparam int COL_W  = `COL_ADDR_WIDTH;
   localparam int WIN_W  = `TX_DATA_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_REQ       = 3'd2,
      S_WAIT      = 3'd3,
      S_EMIT      = 3'd4,
      S_EMIT_LAST = 3'd5,
      S_FIN       = 3'd6
   } scan_state_e;

   typedef struct packed {
      logic [WIN_W-1:0] up;
      logic [WIN_W-1:0] mid;
      logic [WIN_W-1:0] dn;
   } win_t;

   // Staging moves: first chunk of a row has no left neighbour, later ones do.
   typedef enum logic [1:0] {
      SH_NONE  = 2'd0,
      SH_FIRST = 2'd1,
      SH_NEXT  = 2'd2
   } shift_e;

   // Which window to assemble into the output hold register.
   typedef enum logic [1:0] {
      WL_NONE       = 2'd0,
      WL_MID        = 2'd1,
      WL_LAST_FIRST = 2'd2,
      WL_LAST_NEXT  = 2'd3
   } win_load_e;

   // Bit 0 is the left halo, the top bit is the right halo.
   function automatic logic [WIN_W-1:0] make_row(input logic right,
                                                 input logic [DATA_W-1:0] chunk,
                                                 input logic left);
      return {right, chunk, left};
   endfunction
endpackage

// File: rtl/bank_scan_sequencer_window.sv
// scan_window_stage: holds three fetch slots, the current chunk and the
// left-halo bits of the previous chunk. It also assembles and holds the
// output window.
module scan_window_stage
   import aoc_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              slot_we,
   input  logic [1:0]        slot_idx,
   input  logic [DATA_W-1:0] slot_data,
   input  shift_e            shift,
   input  win_load_e         win_load,
   output win_t              win
);
   logic [2:0][DATA_W-1:0] fresh_r;
   logic [2:0][DATA_W-1:0] cur_r;
   logic [2:0]             prev_msb_r;
   logic [2:0][WIN_W-1:0]  row_s;
   win_t                   win_r;

   // Assemble the three window rows from the fresh, current and previous chunk
   always_comb begin
      row_s = '0;
      for (int i = 0; i < 3; i++) begin
         case (win_load)
            WL_MID:        row_s[i] = make_row(fresh_r[i][0], cur_r[i], prev_msb_r[i]);
            WL_LAST_FIRST: row_s[i] = make_row(1'b0, fresh_r[i], 1'b0);
            WL_LAST_NEXT:  row_s[i] = make_row(1'b0, fresh_r[i], cur_r[i][DATA_W-1]);
            default:       row_s[i] = '0;
         endcase
      end
   end

   // Capture fetched rows, shift chunk history and hold the presented window
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fresh_r    <= '0;
         cur_r      <= '0;
         prev_msb_r <= 3'b000;
         win_r      <= '0;
      end else begin
         if (slot_we) begin
            fresh_r[slot_idx] <= slot_data;
         end
         case (shift)
            SH_FIRST: begin
               cur_r      <= fresh_r;
               prev_msb_r <= 3'b000;
            end
            SH_NEXT: begin
               cur_r <= fresh_r;
               for (int i = 0; i < 3; i++) prev_msb_r[i] <= cur_r[i][DATA_W-1];
            end
            default: ;
         endcase
         if (win_load != WL_NONE) begin
            win_r <= win_t'({row_s[0], row_s[1], row_s[2]});
         end
      end
   end

   assign win = win_r;
endmodule

// File: rtl/bank_scan_sequencer.sv
// bank_scan_sequencer: sweeps the grid row by row and chunk by chunk. For
// each chunk it reads the three neighbouring rows from the bank controller
// and emits halo-extended 3-row windows over valid/ready.
// Defining SCAN_STATS_EN adds the stall_cycles output.
module bank_scan_sequencer
   import aoc_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ROW_W-1:0]  num_rows,
   input  logic [COL_W-1:0]  num_chunks,
   output logic              seq_busy,
   output logic              done,
   output logic              bank_read_en,
   output logic [ROW_W-1:0]  bank_row_addr,
   output logic [COL_W-1:0]  bank_col_addr,
   input  logic              bank_busy,
   input  logic              bank_ack,
   input  logic [DATA_W-1:0] bank_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [WIN_W-1:0]  win_up,
   output logic [WIN_W-1:0]  win_mid,
   output logic [WIN_W-1:0]  win_dn,
   output logic [ROW_W-1:0]  win_row,
   output logic [COL_W-1:0]  win_chunk,
   output logic              win_last
`ifdef SCAN_STATS_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);
   localparam logic [ROW_W-1:0] ROW_ONE = {{(ROW_W-1){1'b0}}, 1'b1};
   localparam logic [COL_W-1:0] COL_ONE = {{(COL_W-1){1'b0}}, 1'b1};

   scan_state_e       state_r;
   logic [ROW_W-1:0]  rows_r, r_r;
   logic [COL_W-1:0]  chunks_r, c_r;
   logic [1:0]        k_r;
   logic [ROW_W:0]    r_plus1_s;
   logic [COL_W:0]    c_plus1_s;
   logic              row_oob_s, more_chunks_s, hs_s, last_row_s;
   logic              slot_we_s;
   logic [DATA_W-1:0] slot_data_s;
   shift_e            shift_s;
   win_load_e         win_load_s;
   win_t              win_s;

   assign r_plus1_s     = {1'b0, r_r} + {1'b0, ROW_ONE};
   assign c_plus1_s     = {1'b0, c_r} + {1'b0, COL_ONE};
   assign more_chunks_s = (c_plus1_s < {1'b0, chunks_r});
   assign last_row_s    = (r_plus1_s == {1'b0, rows_r});
   assign row_oob_s     = ((k_r == 2'd0) && (r_r == '0)) ||
                          ((k_r == 2'd2) && (r_plus1_s >= {1'b0, rows_r}));
   assign hs_s          = win_valid && win_ready;

   // Datapath strobes for the window stage, decoded from the current state
   always_comb begin
      slot_we_s   = 1'b0;
      slot_data_s = '0;
      shift_s     = SH_NONE;
      win_load_s  = WL_NONE;
      case (state_r)
         S_FETCH: begin
            if (k_r == 2'd3) begin
               if (c_r == '0) begin
                  shift_s    = SH_FIRST;
                  win_load_s = more_chunks_s ? WL_NONE : WL_LAST_FIRST;
               end else begin
                  win_load_s = WL_MID;
               end
            end else if (row_oob_s) begin
               slot_we_s = 1'b1;
            end else begin
               slot_we_s = 1'b0;
            end
         end
         S_WAIT: begin
            if (bank_ack) begin
               slot_we_s   = 1'b1;
               slot_data_s = bank_data;
            end else begin
               slot_we_s = 1'b0;
            end
         end
         S_EMIT: begin
            if (hs_s) begin
               shift_s    = SH_NEXT;
               win_load_s = more_chunks_s ? WL_NONE : WL_LAST_NEXT;
            end else begin
               shift_s = SH_NONE;
            end
         end
         default: ;
      endcase
   end

   // Scan control FSM with registered handshake and bank request outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= S_IDLE;
         rows_r        <= '0;
         chunks_r      <= '0;
         r_r           <= '0;
         c_r           <= '0;
         k_r           <= 2'd0;
         seq_busy      <= 1'b0;
         done          <= 1'b0;
         bank_read_en  <= 1'b0;
         bank_row_addr <= '0;
         bank_col_addr <= '0;
         win_valid     <= 1'b0;
         win_row       <= '0;
         win_chunk     <= '0;
         win_last      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  rows_r   <= num_rows;
                  chunks_r <= num_chunks;
                  r_r      <= '0;
                  c_r      <= '0;
                  k_r      <= 2'd0;
                  seq_busy <= 1'b1;
                  state_r  <= ((num_rows == '0) || (num_chunks == '0)) ? S_FIN : S_FETCH;
               end
            end
            S_FETCH: begin
               if (k_r == 2'd3) begin
                  k_r     <= 2'd0;
                  win_row <= r_r;
                  if (c_r == '0) begin
                     c_r <= c_plus1_s[COL_W-1:0];
                     if (more_chunks_s) begin
                        state_r <= S_FETCH;
                     end else begin
                        state_r   <= S_EMIT_LAST;
                        win_valid <= 1'b1;
                        win_chunk <= chunks_r - COL_ONE;
                        win_last  <= last_row_s;
                     end
                  end else begin
                     state_r   <= S_EMIT;
                     win_valid <= 1'b1;
                     win_chunk <= c_r - COL_ONE;
                     win_last  <= 1'b0;
                  end
               end else if (row_oob_s) begin
                  k_r <= k_r + 2'd1;
               end else begin
                  bank_row_addr <= r_r + ROW_W'(k_r) - ROW_ONE;
                  bank_col_addr <= c_r * COL_W'(DATA_W);
                  state_r       <= S_REQ;
               end
            end
            S_REQ: begin
               if (!bank_busy) begin
                  bank_read_en <= 1'b1;
                  state_r      <= S_WAIT;
               end
            end
            S_WAIT: begin
               bank_read_en <= 1'b0;
               if (bank_ack) begin
                  k_r     <= k_r + 2'd1;
                  state_r <= S_FETCH;
               end
            end
            S_EMIT: begin
               if (hs_s) begin
                  c_r <= c_plus1_s[COL_W-1:0];
                  if (more_chunks_s) begin
                     win_valid <= 1'b0;
                     state_r   <= S_FETCH;
                  end else begin
                     win_chunk <= chunks_r - COL_ONE;
                     win_last  <= last_row_s;
                     state_r   <= S_EMIT_LAST;
                  end
               end
            end
            S_EMIT_LAST: begin
               if (hs_s) begin
                  win_valid <= 1'b0;
                  win_last  <= 1'b0;
                  if (r_plus1_s < {1'b0, rows_r}) begin
                     r_r     <= r_plus1_s[ROW_W-1:0];
                     c_r     <= '0;
                     k_r     <= 2'd0;
                     state_r <= S_FETCH;
                  end else begin
                     state_r <= S_FIN;
                  end
               end
            end
            S_FIN: begin
               done     <= 1'b1;
               seq_busy <= 1'b0;
               state_r  <= S_IDLE;
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

   scan_window_stage u_window (
      .clock     (clock),
      .reset_n   (reset_n),
      .slot_we   (slot_we_s),
      .slot_idx  (k_r),
      .slot_data (slot_data_s),
      .shift     (shift_s),
      .win_load  (win_load_s),
      .win       (win_s)
   );

   assign win_up  = win_s.up;
   assign win_mid = win_s.mid;
   assign win_dn  = win_s.dn;

`ifdef SCAN_STATS_EN
   logic stall_evt_s;
   assign stall_evt_s = ((state_r == S_REQ) && bank_busy) || (state_r == S_WAIT) ||
                        (((state_r == S_EMIT) || (state_r == S_EMIT_LAST)) && !win_ready);

   // Saturating count of bank and downstream stall cycles, cleared per scan
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= 32'd0;
      end else if ((state_r == S_IDLE) && start) begin
         stall_cycles <= 32'd0;
      end else if (stall_evt_s && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end else begin
         stall_cycles <= stall_cycles;
      end
   end
`endif
endmodule

// File: doc/bank_scan_sequencer.md
Name: bank_scan_sequencer

Overview:
Sequences read traffic to the bank controller after the grid has been loaded. It sweeps every centre row and every column chunk of the roll grid. For each chunk it fetches the rows above, at and below the centre. It then emits a 3-row neighbourhood window with one halo bit on each side to the downstream neighbour-count stage over a valid/ready handshake.

Parameters:
DATA_W, `TX_DATA_WIDTH, bits per chunk transfer; bit i is column (chunk*DATA_W + i).
ROW_W, `BANK_ADDR_WIDTH, row address width.
COL_W, `COL_ADDR_WIDTH, column address width (bank_col_addr = chunk*DATA_W).

Ports:
clock  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begin a scan (ignored unless idle)
num_rows  in  ROW_W  grid rows, sampled on start
num_chunks  in  COL_W  chunks per row, ceil(cols/DATA_W), sampled on start
seq_busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the scan completes
bank_read_en  out  1  one-cycle read request to the bank controller
bank_row_addr  out  ROW_W  row for the request
bank_col_addr  out  COL_W  chunk*DATA_W
bank_busy  in  1  bank controller busy; no request while high
bank_ack  in  1  read data valid this cycle
bank_data  in  DATA_W  read data (partial_vec_out)
win_valid  out  1  window valid
win_ready  in  1  downstream accepts
win_up / win_mid / win_dn  out  DATA_W+2 each  rows r-1 / r / r+1; bit 0 = left halo, bits 1..DATA_W = chunk, bit DATA_W+1 = right halo
win_row  out  ROW_W  centre row r
win_chunk  out  COL_W  chunk index of the window
win_last  out  1  final window of the scan

Behaviour:
- Reset, asynchronous and active-low: state IDLE. All outputs are 0. Window, staging and counters are cleared. A reset asserted mid-scan aborts the scan immediately; bank_read_en drops in the same cycle reset asserts. No done pulse is issued.
- States: IDLE, FETCH, REQ, WAIT, EMIT, EMIT_LAST, FIN.
- IDLE: on start, latch num_rows and num_chunks, and set r=0, c=0, k=0. If either count is 0, go to FIN and emit no reads. Otherwise go to FETCH.
- FETCH (k = 0,1,2 selects row r-1+k):
  - Out-of-range row (r-1 < 0 or r+1 >= num_rows): load all-zeros into slot k and advance k without a bank access.
  - Otherwise go to REQ.
- REQ: wait while bank_busy. When bank_busy is low, pulse bank_read_en for exactly 1 cycle with the row and column addresses held stable. Go to WAIT.
- WAIT: on bank_ack, capture bank_data into slot k. Addresses stay held until ack. A bank_ack outside WAIT is ignored.
- After k=2:
  - If c==0: move the slots to "current" and the old current to "previous" (zeros); no emit.
  - If c>0: go to EMIT for chunk c-1.
  - Right halo = bit 0 of the fresh slots. Left halo = bit DATA_W-1 of the previous chunk (0 when c-1==0).
- EMIT: hold win_valid and all window fields stable until the cycle where win_valid && win_ready. Then shift the staging registers and increment c.
  - If c < num_chunks: return to FETCH.
  - Otherwise go to EMIT_LAST with right halo 0.
- EMIT_LAST: emit chunk num_chunks-1. win_last=1 only when r==num_rows-1. After the handshake: if more rows remain, r++, c=0, go to FETCH; else go to FIN.
- FIN: done=1 for 1 cycle, then IDLE.
- seq_busy = (state != IDLE).
- Read count per chunk: 3, fewer on edge rows. A single-row grid issues 1 read per chunk.
- win_valid never drops without a handshake.
- Columns beyond the grid in the last chunk read back as 0 from the bank; no masking is done here.
- Counters use ROW_W/COL_W wrap-free compares; num_chunks*DATA_W must fit in COL_W. Callers guarantee this.
- A start during a scan is ignored.

Optional Feature:
SCAN_STATS_EN:
- Defined: adds output stall_cycles [31:0]. It counts cycles spent in REQ with bank_busy high, in WAIT, or in EMIT/EMIT_LAST with win_ready low. It clears on an accepted start, saturates at all-ones, and holds after done.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package aoc_pkg holds:
  - the scan_state_e typedef;
  - a window struct (up/mid/dn, each DATA_W+2 bits);
  - localparam WIN_W = `TX_DATA_WIDTH+2.
- One natural sub-module: scan_window_stage, holding the staging registers, halo assembly and output hold register.

Test Plan:
- 3x3 grid, DATA_W=8, num_chunks=1, rows 101/010/101 -> exactly 7 reads. 3 windows are emitted; row 1 window is win_up[3:1]=101, win_mid[3:1]=010, win_dn[3:1]=101, halos 0. win_last is set only on row 2, and done pulses once.
- 1 row, 2 chunks, all '@' -> 2 reads. Chunk 0 has right halo 1 and left halo 0; chunk 1 has left halo 1 and right halo 0. win_up and win_dn are all 0.
- bank_busy held high for 10 cycles at a REQ -> bank_read_en stays low, then a single 1-cycle pulse; addresses stay stable through ack.
- win_ready low for 5 cycles during EMIT -> window fields are unchanged and no new reads are issued. With SCAN_STATS_EN defined, stall_cycles includes those 5 cycles.
- num_rows=0 -> no bank_read_en; done is asserted 2 cycles after start. A start while seq_busy is high is ignored.
- reset_n asserted in WAIT -> outputs go to 0 asynchronously. A fresh start afterwards completes the 3x3 case correctly.
